scan_dump_ctrl: RTL

- Scan-chain sequencer for the memory bank.
- Streams host bytes serially into the bank scan chain through scan_enable/scan_in, and captures the bits leaving scan_out into host bytes, so a full chain pass is a simultaneous dump and reload.
- Sits between a byte-wide debug/host port (valid/ready in both directions) and the bank scan pins.
- Holds busy high so the functional write path stays quiet while a pass is running.

---
 rtl/scan_dump_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/scan_dump_ctrl.sv
// Scan-chain sequencer: streams host bytes into the bank scan chain while the
// bits leaving the chain are packed back into host bytes (dump + reload in one pass).
module scan_dump_ctrl #(
    parameter int CHAIN_LEN = 2056,
    parameter int CNT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] byte_idx,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 scan_enable,
    output logic                 scan_in,
    input  logic                 scan_out
);

    localparam int NBYTES   = (CHAIN_LEN + 7) / 8;
    localparam int LASTBITS = ((CHAIN_LEN % 8) == 0) ? 8 : (CHAIN_LEN % 8);

    localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(NBYTES - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_LAST = CNT_WIDTH'(7);
    localparam logic [CNT_WIDTH-1:0] PART_LAST = CNT_WIDTH'(LASTBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_EMIT
    } state_t;

    state_t               state_reg;
    logic [7:0]           load_reg;
    logic [7:0]           capture_reg;
    logic [CNT_WIDTH-1:0] bit_cnt_reg;
    logic [CNT_WIDTH-1:0] byte_idx_reg;
    logic                 done_reg;

    logic                 last_byte;
    logic                 last_bit;
    logic [7:0]           capture_next;

    assign last_byte = (byte_idx_reg == LAST_BYTE);
    assign last_bit  = (bit_cnt_reg == (last_byte ? PART_LAST : FULL_LAST));

    // Only the bit addressed by the bit counter takes scan_out; the rest hold,
    // so bits beyond a short final byte stay at the zero set during LOAD.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cap
            assign capture_next[gi] = (bit_cnt_reg[2:0] == 3'(gi)) ? scan_out
                                                                   : capture_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            load_reg     <= 8'h00;
            capture_reg  <= 8'h00;
            bit_cnt_reg  <= '0;
            byte_idx_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_reg    <= S_LOAD;
                        byte_idx_reg <= '0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_reg <= S_IDLE;
                    end else if (in_valid) begin
                        load_reg    <= in_data;
                        capture_reg <= 8'h00;
                        bit_cnt_reg <= '0;
                        state_reg   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // The shift edge happens even when abort is sampled here.
                    capture_reg <= capture_next;
                    load_reg    <= {1'b0, load_reg[7:1]};
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    if (abort) begin
                        state_reg <= S_IDLE;
                    end else if (last_bit) begin
                        state_reg <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (abort) begin
                        state_reg <= S_IDLE;
                    end else if (out_ready) begin
                        if (last_byte) begin
                            state_reg <= S_IDLE;
                            done_reg  <= 1'b1;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            state_reg    <= S_LOAD;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign done        = done_reg;
    assign byte_idx    = byte_idx_reg;
    assign in_ready    = (state_reg == S_LOAD);
    assign out_valid   = (state_reg == S_EMIT);
    assign out_data    = capture_reg;
    assign scan_enable = (state_reg == S_SHIFT);
    assign scan_in     = (state_reg == S_SHIFT) && load_reg[0];

endmodule
